// File: rtl/sched_pkg.sv
// Shared types, sizing constants and helpers for the commit-slot wakeup tracker.
package sched_pkg;
    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = $clog2(NCOMMIT);
    localparam int NDEC     = 4;
    localparam int NWAKE    = 4;
    localparam int NISSUE   = 6;
    localparam int NUNIT    = 7;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        SHIFT  = 3'd1,
        MUL    = 3'd2,
        LOAD   = 3'd3,
        STORE  = 3'd4,
        BRANCH = 3'd5,
        FPU    = 3'd6
    } unit_t;

    function automatic logic [LNCOMMIT:0] popcount(input logic [NCOMMIT-1:0] v);
        logic [LNCOMMIT:0] c;
        c = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            c = c + (LNCOMMIT+1)'(v[i]);
        end
        return c;
    endfunction
endpackage

// File: rtl/sched_ready_track_if.sv
// Allocation / wakeup / issue / flush bus into the tracker and its ready vectors out.
interface sched_ready_track_if;
    import sched_pkg::*;

    logic [NDEC-1:0]            alloc_valid;
    logic [NDEC*LNCOMMIT-1:0]   alloc_idx;
    logic [NDEC*3-1:0]          alloc_unit;
    logic [NDEC*NCOMMIT-1:0]    alloc_dep;
    logic [NWAKE-1:0]           wake_valid;
    logic [NWAKE*LNCOMMIT-1:0]  wake_idx;
    logic [NISSUE-1:0]          issue_valid;
    logic [NISSUE*LNCOMMIT-1:0] issue_idx;
    logic [NCOMMIT-1:0]         kill_mask;

    logic [NCOMMIT-1:0] ready_alu;
    logic [NCOMMIT-1:0] ready_shift;
    logic [NCOMMIT-1:0] ready_mul;
    logic [NCOMMIT-1:0] ready_load;
    logic [NCOMMIT-1:0] ready_store;
    logic [NCOMMIT-1:0] ready_branch;
    logic [NCOMMIT-1:0] ready_fpu;
    logic [LNCOMMIT:0]  n_waiting;
    logic               alloc_err;

    modport master (
        output alloc_valid, alloc_idx, alloc_unit, alloc_dep,
        output wake_valid, wake_idx, issue_valid, issue_idx, kill_mask,
        input  ready_alu, ready_shift, ready_mul, ready_load, ready_store,
        input  ready_branch, ready_fpu, n_waiting, alloc_err
    );

    modport slave (
        input  alloc_valid, alloc_idx, alloc_unit, alloc_dep,
        input  wake_valid, wake_idx, issue_valid, issue_idx, kill_mask,
        output ready_alu, ready_shift, ready_mul, ready_load, ready_store,
        output ready_branch, ready_fpu, n_waiting, alloc_err
    );
endinterface

// File: rtl/sched_ready_entry.sv
// One commit slot: pending flag, unit class and dependency mask, plus its ready decode.
module sched_ready_entry
    import sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_i,
    input  unit_t              alloc_unit_i,
    input  logic [NCOMMIT-1:0] alloc_dep_i,
    input  logic               issue_i,
    input  logic               kill_i,
    input  logic [NCOMMIT-1:0] wake_col_i,
    output logic               pend_o,
    output logic [NUNIT-1:0]   ready_o
);
    logic               pend_q, pend_d;
    unit_t              unit_q, unit_d;
    logic [NCOMMIT-1:0] dep_q, dep_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            unit_q <= ALU;
            dep_q  <= '0;
        end else begin
            pend_q <= pend_d;
            unit_q <= unit_d;
            dep_q  <= dep_d;
        end
    end

    // Later steps override earlier ones: wake, then issue, then kill, then alloc.
    always_comb begin
        pend_d = pend_q;
        unit_d = unit_q;
        dep_d  = dep_q & ~wake_col_i;
        if (issue_i) begin
            pend_d = 1'b0;
        end
        if (kill_i) begin
            pend_d = 1'b0;
            dep_d  = '0;
        end
        if (alloc_i) begin
            pend_d = 1'b1;
            unit_d = alloc_unit_i;
            dep_d  = alloc_dep_i;
        end
    end

    assign pend_o  = pend_q;
    assign ready_o = (pend_q && dep_q == '0) ? (NUNIT'(1) << unit_q) : '0;
endmodule

// File: rtl/sched_ready_track.sv
// Wakeup tracker feeding the ALU scheduler: decodes alloc/wake/issue/kill per slot and
// publishes per-class ready vectors, the pending count and a sticky allocation error.
module sched_ready_track
    import sched_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    sched_ready_track_if.slave  bus
);
    logic [NCOMMIT-1:0] wake_col;
    logic [NCOMMIT-1:0] issue_hit;
    logic [NCOMMIT-1:0] alloc_hit;
    logic [NCOMMIT-1:0] collide;
    logic [NCOMMIT-1:0] pend;
    logic [NCOMMIT-1:0] r_alu, r_shift, r_mul, r_load, r_store, r_branch, r_fpu;
    logic               err_q, err_d;

    always_comb begin
        wake_col = '0;
        for (int w = 0; w < NWAKE; w++) begin
            if (bus.wake_valid[w]) begin
                wake_col[bus.wake_idx[w*LNCOMMIT +: LNCOMMIT]] = 1'b1;
            end
        end
    end

    always_comb begin
        issue_hit = '0;
        for (int i = 0; i < NISSUE; i++) begin
            if (bus.issue_valid[i]) begin
                issue_hit[bus.issue_idx[i*LNCOMMIT +: LNCOMMIT]] = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NCOMMIT; gi++) begin : g_slot
        logic               hit, col;
        unit_t              unit_sel;
        logic [NCOMMIT-1:0] dep_sel;
        logic [NCOMMIT-1:0] dep_masked;
        logic [NUNIT-1:0]   rdy;

        // Scan lanes in ascending order so the highest-numbered matching lane wins.
        always_comb begin
            hit      = 1'b0;
            col      = 1'b0;
            unit_sel = ALU;
            dep_sel  = '0;
            for (int l = 0; l < NDEC; l++) begin
                if (bus.alloc_valid[l] &&
                    bus.alloc_idx[l*LNCOMMIT +: LNCOMMIT] == LNCOMMIT'(gi)) begin
                    col      = col | hit;
                    hit      = 1'b1;
                    unit_sel = unit_t'(bus.alloc_unit[l*3 +: 3]);
                    dep_sel  = bus.alloc_dep[l*NCOMMIT +: NCOMMIT];
                end
            end
        end

        // Producers woken or flushed this cycle, and the slot itself, never gate the new op.
        assign dep_masked    = dep_sel & ~wake_col & ~bus.kill_mask & ~(NCOMMIT'(1) << gi);
        assign alloc_hit[gi] = hit;
        assign collide[gi]   = col;

        sched_ready_entry u_entry (
            .clk          (clk),
            .reset        (reset),
            .alloc_i      (hit),
            .alloc_unit_i (unit_sel),
            .alloc_dep_i  (dep_masked),
            .issue_i      (issue_hit[gi]),
            .kill_i       (bus.kill_mask[gi]),
            .wake_col_i   (wake_col),
            .pend_o       (pend[gi]),
            .ready_o      (rdy)
        );

        assign r_alu[gi]    = rdy[ALU];
        assign r_shift[gi]  = rdy[SHIFT];
        assign r_mul[gi]    = rdy[MUL];
        assign r_load[gi]   = rdy[LOAD];
        assign r_store[gi]  = rdy[STORE];
        assign r_branch[gi] = rdy[BRANCH];
        assign r_fpu[gi]    = rdy[FPU];
    end

    // Overwriting a live op is an error; a slot freed by issue or kill this cycle is fair game.
    always_comb begin
        err_d = err_q | (|collide) | (|(alloc_hit & pend & ~bus.kill_mask & ~issue_hit));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ready_alu    = r_alu;
    assign bus.ready_shift  = r_shift;
    assign bus.ready_mul    = r_mul;
    assign bus.ready_load   = r_load;
    assign bus.ready_store  = r_store;
    assign bus.ready_branch = r_branch;
    assign bus.ready_fpu    = r_fpu;
    assign bus.n_waiting    = popcount(pend);
    assign bus.alloc_err    = err_q;
endmodule
